// File: rtl/sr_pulse_ctrl.sv
// Purpose: turns two bouncy async buttons into clean, spaced, single-cycle set/reset/enable pulses for an SR latch.
// Latency: a held press emits its pulse 2+DEB_CYCLES edges after the first sampling edge.
// Backpressure: none; requests arriving mid-pulse are held as pending, and colliding requests are dropped with a conflict flag.
module sr_pulse_ctrl #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_clr,
    output logic s,
    output logic r,
    output logic en,
    output logic conflict
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    // Channel index 0 is set, index 1 is clear.
    logic [1:0]    raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    db_q;
    logic [1:0]    db_d;
    logic [1:0]    db_dly_q;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    req;
    logic [1:0]    eff;
    logic [1:0]    pend_q;
    logic [1:0]    pend_d;
    logic          conflict_q;
    logic          conflict_d;
    state_t        state_q;
    state_t        state_d;

    assign raw = {btn_clr, btn_set};

    // Two-flop synchronizers for both raw button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a new synchronized level must persist DEB_CYCLES cycles before it is accepted.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Debounced levels, their counters and one-cycle history for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q     <= '0;
            db_dly_q <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    // Only presses matter; releases are ignored.
    assign req = db_q & ~db_dly_q;
    assign eff = req | pend_q;

    // Next state: IDLE and GAP consume every outstanding request, pulses park new ones as pending.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        conflict_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                pend_d = '0;
                if (eff == 2'b11) begin
                    state_d    = IDLE;
                    conflict_d = 1'b1;
                end else if (eff[0]) begin
                    state_d = PULSE_S;
                end else if (eff[1]) begin
                    state_d = PULSE_R;
                end else begin
                    state_d = IDLE;
                end
            end
            PULSE_S, PULSE_R: begin
                pend_d  = pend_q | req;
                state_d = GAP;
            end
            default: begin
                pend_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, pending requests and conflict flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            conflict_q <= conflict_d;
        end
    end

    // Moore outputs taken straight from registers so the latch sees glitch-free levels.
    assign s        = (state_q == PULSE_S);
    assign r        = (state_q == PULSE_R);
    assign en       = s | r;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_pulse_ctrl.sv
module tb_sr_pulse_ctrl;

    typedef struct {
        int   cyc;
        logic s;
        logic r;
        logic c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_set = 1'b0;
    logic btn_clr = 1'b0;
    logic s;
    logic r;
    logic en;
    logic conflict;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    sr_pulse_ctrl #(.DEB_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_set  (btn_set),
        .btn_clr  (btn_clr),
        .s        (s),
        .r        (r),
        .en       (en),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every active output cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            checks++;
            if ((s & r) !== 1'b0 || en !== (s | r)) begin
                errors++;
                $display("FAIL invariant cyc=%0d s=%b r=%b en=%b required s&r=0 and en=s|r", cyc, s, r, en);
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event expected at cyc=%0d s=%b r=%b conflict=%b, nothing seen", e.cyc, e.s, e.r, e.c);
            end
            if (s | r | en | conflict) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d s=%b r=%b en=%b conflict=%b required all 0", cyc, s, r, en, conflict);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.s !== s || e.r !== r || e.c !== conflict) begin
                        errors++;
                        $display("FAIL event got cyc=%0d s=%b r=%b conflict=%b required cyc=%0d s=%b r=%b conflict=%b",
                                 cyc, s, r, conflict, e.cyc, e.s, e.r, e.c);
                    end
                end
            end
        end
    end

    task automatic push(input int c, input logic es, input logic er, input logic ec);
        exp_t e;
        e.cyc = c;
        e.s   = es;
        e.r   = er;
        e.c   = ec;
        sb.push_back(e);
    endtask

    // Wait (bounded) for all expected events, then idle to catch stray pulses.
    task automatic wait_drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
            sb.delete();
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        btn_set = 1'b1;
        btn_clr = 1'b1;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({s, r, en, conflict} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_immediate got s=%b r=%b en=%b conflict=%b required 0000", s, r, en, conflict);
        end
        btn_clr = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({s, r, en, conflict} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_held got s=%b r=%b en=%b conflict=%b required 0000", s, r, en, conflict);
        end
        @(negedge clk);
        rst = 1'b0;
        push(cyc + 7, 1'b1, 1'b0, 1'b0);
        wait_drain("reset_release");
        btn_set = 1'b0;
        wait_drain("reset_release_btn");
    endtask

    task automatic test_clean_press();
        @(negedge clk);
        btn_set = 1'b1;
        push(cyc + 7, 1'b1, 1'b0, 1'b0);
        wait_drain("clean_press");
        btn_set = 1'b0;
        wait_drain("clean_release");
    endtask

    task automatic test_bounce();
        int n;
        @(negedge clk);
        n = cyc;
        btn_clr = 1'b1;
        repeat (3) @(negedge clk);
        btn_clr = 1'b0;
        @(negedge clk);
        btn_clr = 1'b1;
        push(n + 11, 1'b0, 1'b1, 1'b0);
        wait_drain("bounce");
        btn_clr = 1'b0;
        wait_drain("bounce_release");
    endtask

    task automatic test_collision();
        @(negedge clk);
        btn_set = 1'b1;
        btn_clr = 1'b1;
        push(cyc + 7, 1'b0, 1'b0, 1'b1);
        wait_drain("collision");
        btn_set = 1'b0;
        btn_clr = 1'b0;
        wait_drain("collision_release");
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        n = cyc;
        btn_set = 1'b1;
        @(negedge clk);
        btn_clr = 1'b1;
        push(n + 7, 1'b1, 1'b0, 1'b0);
        push(n + 9, 1'b0, 1'b1, 1'b0);
        wait_drain("back_to_back");
        btn_set = 1'b0;
        btn_clr = 1'b0;
        wait_drain("back_to_back_release");
    endtask

    task automatic test_mid_reset();
        int n;
        @(negedge clk);
        n = cyc;
        btn_set = 1'b1;
        push(n + 7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (cyc >= n + 7) break;
            @(negedge clk);
        end
        checks++;
        if (s !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pulse_present got s=%b required 1", s);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s, r, en, conflict} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_async got s=%b r=%b en=%b conflict=%b required 0000", s, r, en, conflict);
        end
        btn_set = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_scoreboard pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_collision();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_pulse_ctrl.md
# sr_pulse_ctrl

Front-end control stage that converts two raw, bouncy, asynchronous push-button inputs into clean, registered, single-cycle set/reset/enable pulses for the downstream SR latch. Each channel is synchronized, debounced and rising-edge detected. A small FSM spaces pulses apart and never drives set and reset together, which keeps the latch out of its undefined state. Simultaneous set and clear requests are reported on a conflict flag instead of being forwarded.

## Interface
- DEB_CYCLES, 4: consecutive post-sync cycles a new level must hold before it is accepted; legal range ≥1. Counter width is clog2(DEB_CYCLES+1).
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_set  input  1  raw set button, asynchronous to clk, may bounce.
- btn_clr  input  1  raw clear button, asynchronous to clk, may bounce.
- s  output  1  registered set pulse to the latch.
- r  output  1  registered reset pulse to the latch.
- en  output  1  registered latch enable; high exactly when s or r is high.
- conflict  output  1  registered one-cycle flag: a set and a clear request collided and both were dropped.

## Operation
- Reset is asynchronous and active-high. While rst=1, all of the following are 0: sync FFs, debounced levels db_set/db_clr, debounce counters, edge history, pending flags, s, r, en and conflict. The FSM is in IDLE.
- Sync: each button passes through a 2-FF synchronizer, giving sync_x.
- Debounce, per channel, on every clock edge:
  - if sync_x==db_x, cnt_x<=0;
  - else if cnt_x==DEB_CYCLES-1, db_x<=sync_x and cnt_x<=0;
  - else cnt_x<=cnt_x+1.
  - Any return to the old level before DEB_CYCLES cycles restarts the count.
- Edge detect: req_x = db_x & ~db_x_d (combinational; db_x_d is db_x delayed one cycle). Falling edges (button release) produce nothing.
- Pending flags pend_set/pend_clr capture requests that arrive in PULSE_S, PULSE_R or GAP. A flag already set stays set; a repeat request does not queue a second pulse.
- FSM states: IDLE, PULSE_S, PULSE_R, GAP. Outputs are Moore and registered.
  - s=1 only in PULSE_S; r=1 only in PULSE_R; en=s|r.
- Transitions. "Eff_x" is req_x | pend_x, evaluated in IDLE and GAP:
  - IDLE/GAP: eff_set only → PULSE_S; eff_clr only → PULSE_R; both → IDLE with conflict=1 for one cycle and both pend flags cleared; neither → IDLE.
  - When a pending flag is consumed, it clears on that edge.
  - PULSE_S/PULSE_R → GAP unconditionally, so en is low for at least one cycle between pulses.
- Invariant: s&r is never 1. Any two requests not separated by an issued pulse collapse into a conflict.

## Timing
- Define edge k as the first clock edge that samples the new raw level into sync stage 1.
- sync_x takes the new level after edge k+1.
- db_x takes the new level after edge k+1+DEB_CYCLES, provided the level is held with no bounce.
- s (or r) and en go high after edge k+2+DEB_CYCLES (k+6 for DEB_CYCLES=4) and stay high for exactly one cycle.
- Back-to-back requests: the minimum spacing between pulse starts is 2 cycles (PULSE → GAP → PULSE).
- conflict is asserted in the cycle after the colliding evaluation and lasts one cycle. s, r and en stay 0 in that cycle.
- If rst is asserted mid-pulse or mid-debounce, outputs drop to 0 immediately (asynchronously). After release, a button still held high must re-debounce from db=0 and then produces one pulse.

## Test plan
- Reset: assert rst with both buttons high → s=r=en=conflict=0 immediately. Release rst and keep btn_set high → single s pulse at k+6 (DEB_CYCLES=4).
- Clean press: btn_set 0→1 sampled at edge 10 and held → s=en=1 only in the cycle after edge 16; r=0 throughout; releasing the button later produces no pulse.
- Bounce rejection: btn_clr toggles high for 3 cycles, low for 1, then high and held → exactly one r pulse, starting 6 edges after the final rise is sampled.
- Collision: both buttons rise at the same sampled edge → conflict=1 for one cycle, s=r=en=0 throughout.
- Spacing: the clr request arrives one cycle after the set request → s pulse, then a GAP cycle with en=0, then an r pulse. s&r is never 1.
- Mid-operation reset: assert rst during a PULSE_S cycle → s and en clear asynchronously in the same cycle; no pulse appears after rst release until a new debounced edge occurs.
